bru_issue_queue: RTL and testbench

// - In-order issue queue and scheduler in front of the branch unit (FU_BRU). Buffers dispatched

---
 rtl/bru_issue_queue_pkg.sv | 27 ++
 rtl/bru_issue_queue_entry.sv | 117 +++++++++++
 rtl/bru_issue_queue.sv | 132 +++++++++++++
 tb/tb_bru_issue_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bru_issue_queue_pkg.sv
// Shared definitions for the branch-unit issue queue: op encoding, tag and data widths.
`ifndef INST_STATE_WD
`define INST_STATE_WD 64
`endif

package bru_issue_queue_pkg;
  localparam int BRU_OP_W   = 12;
  localparam int BRU_TAG_W  = 6;
  localparam int BRU_DATA_W = 32;

  // One-hot bit positions, beq is the MSB.
  localparam int OP_BEQ    = 11;
  localparam int OP_BNE    = 10;
  localparam int OP_BGEZ   = 9;
  localparam int OP_BGTZ   = 8;
  localparam int OP_BLEZ   = 7;
  localparam int OP_BLTZ   = 6;
  localparam int OP_BGEZAL = 5;
  localparam int OP_BLTZAL = 4;
  localparam int OP_J      = 3;
  localparam int OP_JAL    = 2;
  localparam int OP_JR     = 1;
  localparam int OP_JALR   = 0;

  typedef logic [BRU_OP_W-1:0]   bru_op_t;
  typedef logic [BRU_DATA_W-1:0] bru_data_t;
endpackage

// File: rtl/bru_issue_queue_entry.sv
// One issue-queue slot: holds a branch op with its two source operands and
// captures missing operands from the CDB.
module bru_iq_entry
  import bru_issue_queue_pkg::*;
#(
  parameter int TAG_W = BRU_TAG_W,
  parameter int ST_W  = `INST_STATE_WD
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             deq_i,
  input  bru_op_t          op_i,
  input  logic [ST_W-1:0]  status_i,
  input  logic [TAG_W-1:0] s1_tag_i,
  input  logic [TAG_W-1:0] s2_tag_i,
  input  logic             s1_rdy_i,
  input  logic             s2_rdy_i,
  input  bru_data_t        s1_data_i,
  input  bru_data_t        s2_data_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  bru_data_t        cdb_data_i,
  output logic             valid_o,
  output logic             rdy1_o,
  output logic             rdy2_o,
  output bru_op_t          op_o,
  output logic [ST_W-1:0]  status_o,
  output bru_data_t        data1_o,
  output bru_data_t        data2_o
);
  logic             valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  bru_op_t          op_q, op_d;
  logic [ST_W-1:0]  status_q, status_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  bru_data_t        data1_q, data1_d, data2_q, data2_d;
  logic             wake1_s, wake2_s;

  assign wake1_s = cdb_valid_i & (cdb_tag_i == tag1_q) & valid_q & ~rdy1_q;
  assign wake2_s = cdb_valid_i & (cdb_tag_i == tag2_q) & valid_q & ~rdy2_q;

  // Next state: clear beats load beats dequeue/wakeup.
  always_comb begin
    valid_d  = valid_q;
    rdy1_d   = rdy1_q;
    rdy2_d   = rdy2_q;
    op_d     = op_q;
    status_d = status_q;
    tag1_d   = tag1_q;
    tag2_d   = tag2_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    if (clr_i) begin
      valid_d = 1'b0;
      rdy1_d  = 1'b0;
      rdy2_d  = 1'b0;
    end else if (load_i) begin
      valid_d  = 1'b1;
      op_d     = op_i;
      status_d = status_i;
      tag1_d   = s1_tag_i;
      tag2_d   = s2_tag_i;
      rdy1_d   = s1_rdy_i | (cdb_valid_i & (cdb_tag_i == s1_tag_i));
      rdy2_d   = s2_rdy_i | (cdb_valid_i & (cdb_tag_i == s2_tag_i));
      data1_d  = s1_rdy_i ? s1_data_i : cdb_data_i;
      data2_d  = s2_rdy_i ? s2_data_i : cdb_data_i;
    end else begin
      valid_d = deq_i ? 1'b0 : valid_q;
      if (wake1_s) begin
        rdy1_d  = 1'b1;
        data1_d = cdb_data_i;
      end else begin
        rdy1_d  = rdy1_q;
      end
      if (wake2_s) begin
        rdy2_d  = 1'b1;
        data2_d = cdb_data_i;
      end else begin
        rdy2_d  = rdy2_q;
      end
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      rdy1_q   <= 1'b0;
      rdy2_q   <= 1'b0;
      op_q     <= '0;
      status_q <= '0;
      tag1_q   <= '0;
      tag2_q   <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rdy1_q   <= rdy1_d;
      rdy2_q   <= rdy2_d;
      op_q     <= op_d;
      status_q <= status_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
    end
  end

  assign valid_o  = valid_q;
  assign rdy1_o   = rdy1_q;
  assign rdy2_o   = rdy2_q;
  assign op_o     = op_q;
  assign status_o = status_q;
  assign data1_o  = data1_q;
  assign data2_o  = data2_q;
endmodule

// File: rtl/bru_issue_queue.sv
// In-order issue queue for the branch unit: circular buffer of bru_iq_entry slots,
// head issues once both operands are ready; redirect/flush empties the queue.
module bru_issue_queue
  import bru_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = BRU_TAG_W,
  parameter int ST_W  = `INST_STATE_WD
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush_i,
  input  logic                     bru_br_e,
  input  logic                     dsp_valid,
  output logic                     dsp_ready,
  input  bru_op_t                  dsp_op,
  input  logic [ST_W-1:0]          dsp_status,
  input  logic [TAG_W-1:0]         dsp_s1_tag,
  input  logic [TAG_W-1:0]         dsp_s2_tag,
  input  logic                     dsp_s1_rdy,
  input  logic                     dsp_s2_rdy,
  input  bru_data_t                dsp_s1_data,
  input  bru_data_t                dsp_s2_data,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  bru_data_t                cdb_data,
  output logic                     iss_valid,
  output bru_op_t                  iss_op,
  output logic [ST_W-1:0]          iss_status,
  output bru_data_t                iss_rdata1,
  output bru_data_t                iss_rdata2,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_s, enq_s, deq_s;
  logic [DEPTH-1:0] e_valid_s, e_rdy1_s, e_rdy2_s, e_load_s, e_deq_s;
  bru_op_t          e_op_s     [DEPTH];
  logic [ST_W-1:0]  e_status_s [DEPTH];
  bru_data_t        e_data1_s  [DEPTH];
  bru_data_t        e_data2_s  [DEPTH];

  assign flush_s   = flush_i | bru_br_e;
  // No credit for a same-cycle issue: readiness depends on registered count only.
  assign dsp_ready = (count_q != CNT_W'(DEPTH)) & ~flush_s;
  assign enq_s     = dsp_valid & dsp_ready;
  assign deq_s     = e_valid_s[head_q] & e_rdy1_s[head_q] & e_rdy2_s[head_q] & ~flush_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign e_load_s[g] = enq_s & (tail_q == PTR_W'(g));
    assign e_deq_s[g]  = deq_s & (head_q == PTR_W'(g));
    bru_iq_entry #(.TAG_W(TAG_W), .ST_W(ST_W)) u_entry (
      .clk         (clk),
      .resetn      (resetn),
      .clr_i       (flush_s),
      .load_i      (e_load_s[g]),
      .deq_i       (e_deq_s[g]),
      .op_i        (dsp_op),
      .status_i    (dsp_status),
      .s1_tag_i    (dsp_s1_tag),
      .s2_tag_i    (dsp_s2_tag),
      .s1_rdy_i    (dsp_s1_rdy),
      .s2_rdy_i    (dsp_s2_rdy),
      .s1_data_i   (dsp_s1_data),
      .s2_data_i   (dsp_s2_data),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_data_i  (cdb_data),
      .valid_o     (e_valid_s[g]),
      .rdy1_o      (e_rdy1_s[g]),
      .rdy2_o      (e_rdy2_s[g]),
      .op_o        (e_op_s[g]),
      .status_o    (e_status_s[g]),
      .data1_o     (e_data1_s[g]),
      .data2_o     (e_data2_s[g])
    );
  end

  // Pointer and count update.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_s) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d = deq_s ? head_q + PTR_W'(1) : head_q;
      tail_d = enq_s ? tail_q + PTR_W'(1) : tail_q;
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Issue port is forced to zero when nothing issues.
  always_comb begin
    if (deq_s) begin
      iss_op     = e_op_s[head_q];
      iss_status = e_status_s[head_q];
      iss_rdata1 = e_data1_s[head_q];
      iss_rdata2 = e_data2_s[head_q];
    end else begin
      iss_op     = '0;
      iss_status = '0;
      iss_rdata1 = '0;
      iss_rdata2 = '0;
    end
  end

  assign iss_valid = deq_s;
  assign occupancy = count_q;
endmodule

// File: tb/tb_bru_issue_queue.sv
// Directed bench for bru_issue_queue with an in-order scoreboard of expected issues.
`ifndef INST_STATE_WD
`define INST_STATE_WD 64
`endif

module tb_bru_issue_queue;
  import bru_issue_queue_pkg::*;

  localparam int ST_W = `INST_STATE_WD;
  localparam bru_op_t BEQ  = 12'h800;
  localparam bru_op_t BNE  = 12'h400;
  localparam bru_op_t BGEZ = 12'h200;
  localparam bru_op_t BGTZ = 12'h100;
  localparam bru_op_t BLEZ = 12'h080;
  localparam bru_op_t JR   = 12'h002;

  logic            clk = 1'b0;
  logic            resetn, flush_i, bru_br_e, dsp_valid, dsp_ready;
  bru_op_t         dsp_op, iss_op;
  logic [ST_W-1:0] dsp_status, iss_status;
  logic [5:0]      dsp_s1_tag, dsp_s2_tag, cdb_tag;
  logic            dsp_s1_rdy, dsp_s2_rdy, cdb_valid, iss_valid;
  bru_data_t       dsp_s1_data, dsp_s2_data, cdb_data, iss_rdata1, iss_rdata2;
  logic [2:0]      occupancy;

  typedef struct packed {
    bru_op_t         op;
    logic [ST_W-1:0] st;
    bru_data_t       d1;
    bru_data_t       d2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   issues = 0;
  int   issues0;

  bru_issue_queue dut (
    .clk(clk), .resetn(resetn), .flush_i(flush_i), .bru_br_e(bru_br_e),
    .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_op(dsp_op), .dsp_status(dsp_status),
    .dsp_s1_tag(dsp_s1_tag), .dsp_s2_tag(dsp_s2_tag), .dsp_s1_rdy(dsp_s1_rdy),
    .dsp_s2_rdy(dsp_s2_rdy), .dsp_s1_data(dsp_s1_data), .dsp_s2_data(dsp_s2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_status(iss_status),
    .iss_rdata1(iss_rdata1), .iss_rdata2(iss_rdata2), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  // Drive one dispatch for a cycle and record its expected issue.
  task automatic disp(input bru_op_t op, input logic [ST_W-1:0] st,
                      input logic r1, input logic [5:0] t1, input bru_data_t d1,
                      input logic r2, input logic [5:0] t2, input bru_data_t d2,
                      input bru_data_t e1, input bru_data_t e2);
    exp_t e;
    dsp_valid = 1'b1; dsp_op = op; dsp_status = st;
    dsp_s1_rdy = r1; dsp_s1_tag = t1; dsp_s1_data = d1;
    dsp_s2_rdy = r2; dsp_s2_tag = t2; dsp_s2_data = d2;
    look();
    chk("dsp_ready_on_dispatch", 128'(dsp_ready), 128'(1));
    e.op = op; e.st = st; e.d1 = e1; e.d2 = e2;
    sb.push_back(e);
    cyc();
    dsp_valid = 1'b0;
  endtask

  // Fill with a blocked head, release it, then redirect/flush one cycle after that issue.
  task automatic flush_test(input logic use_flush);
    disp(BLEZ, 64'hF0, 1'b0, 6'd20, 32'h0, 1'b1, 6'd0, 32'h1, 32'h55, 32'h1);
    for (int i = 0; i < 3; i++)
      disp(BGTZ, ST_W'(64'hF1 + i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i + 8), 32'(i), 32'(i + 8));
    cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'h55;
    cyc();
    cdb_valid = 1'b0;
    look();
    chk("flush_pre_issue", 128'(iss_valid), 128'(1));
    cyc();
    if (use_flush) flush_i = 1'b1; else bru_br_e = 1'b1;
    dsp_valid = 1'b1; dsp_s1_rdy = 1'b1; dsp_s2_rdy = 1'b1;
    look();
    chk("flush_no_issue", 128'(iss_valid), 128'(0));
    chk("flush_iss_op_zero", 128'(iss_op), 128'(0));
    chk("flush_dsp_ready", 128'(dsp_ready), 128'(0));
    chk("flush_occ_before", 128'(occupancy), 128'(3));
    sb.delete();
    cyc();
    flush_i = 1'b0; bru_br_e = 1'b0; dsp_valid = 1'b0;
    look();
    chk("flush_occ_after", 128'(occupancy), 128'(0));
    chk("flush_iss_after", 128'(iss_valid), 128'(0));
    chk("flush_ready_after", 128'(dsp_ready), 128'(1));
    cyc();
  endtask

  // Every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && iss_valid) begin
      issues++;
      if (sb.size() == 0) begin
        chk("unexpected_issue", 128'(iss_op), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("sb_op", 128'(iss_op), 128'(mon_e.op));
        chk("sb_status", 128'(iss_status), 128'(mon_e.st));
        chk("sb_rdata1", 128'(iss_rdata1), 128'(mon_e.d1));
        chk("sb_rdata2", 128'(iss_rdata2), 128'(mon_e.d2));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; flush_i = 1'b0; bru_br_e = 1'b0; dsp_valid = 1'b0;
    dsp_op = '0; dsp_status = '0; dsp_s1_tag = '0; dsp_s2_tag = '0;
    dsp_s1_rdy = 1'b0; dsp_s2_rdy = 1'b0; dsp_s1_data = '0; dsp_s2_data = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    look();
    chk("reset_dsp_ready", 128'(dsp_ready), 128'(1));
    chk("reset_iss_valid", 128'(iss_valid), 128'(0));
    chk("reset_occupancy", 128'(occupancy), 128'(0));
    chk("reset_iss_op", 128'(iss_op), 128'(0));
    chk("reset_iss_rdata1", 128'(iss_rdata1), 128'(0));

    // beq with both operands ready: issues the following cycle, never the same cycle.
    dsp_valid = 1'b1; dsp_op = BEQ; dsp_status = 64'hA0;
    dsp_s1_rdy = 1'b1; dsp_s1_tag = 6'd1; dsp_s1_data = 32'd5;
    dsp_s2_rdy = 1'b1; dsp_s2_tag = 6'd2; dsp_s2_data = 32'd5;
    look();
    chk("t1_no_same_cycle_issue", 128'(iss_valid), 128'(0));
    sb.push_back('{op: BEQ, st: 64'hA0, d1: 32'd5, d2: 32'd5});
    cyc();
    dsp_valid = 1'b0;
    look();
    chk("t1_iss_valid", 128'(iss_valid), 128'(1));
    chk("t1_iss_op", 128'(iss_op), 128'(12'h800));
    chk("t1_rdata1", 128'(iss_rdata1), 128'(5));
    chk("t1_rdata2", 128'(iss_rdata2), 128'(5));
    cyc();
    look();
    chk("t1_drained", 128'(occupancy), 128'(0));

    // jr waiting on tag 3, broadcast two cycles after dispatch.
    disp(JR, 64'hB0, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'h0, 32'h8000_0100, 32'h0);
    look();
    chk("t2_wait0", 128'(iss_valid), 128'(0));
    cyc();
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h8000_0100;
    look();
    chk("t2_wait1", 128'(iss_valid), 128'(0));
    cyc();
    cdb_valid = 1'b0;
    look();
    chk("t2_iss_valid", 128'(iss_valid), 128'(1));
    chk("t2_rdata1", 128'(iss_rdata1), 128'(32'h8000_0100));
    cyc();

    // Fill all four slots behind a blocked head.
    disp(BNE, 64'hC0, 1'b0, 6'd10, 32'h0, 1'b1, 6'd0, 32'h11, 32'h77, 32'h11);
    for (int i = 0; i < 3; i++)
      disp(BEQ, ST_W'(64'hC1 + i), 1'b1, 6'd0, 32'(100 + i), 1'b1, 6'd0, 32'(200 + i),
           32'(100 + i), 32'(200 + i));
    look();
    chk("t3_full_occ", 128'(occupancy), 128'(4));
    chk("t3_full_ready", 128'(dsp_ready), 128'(0));
    chk("t3_blocked", 128'(iss_valid), 128'(0));
    dsp_valid = 1'b1; dsp_op = BGEZ; dsp_s1_rdy = 1'b1; dsp_s2_rdy = 1'b1;
    cyc();
    dsp_valid = 1'b0;
    look();
    chk("t3_reject_occ", 128'(occupancy), 128'(4));
    cdb_valid = 1'b1; cdb_tag = 6'd10; cdb_data = 32'h77;
    cyc();
    cdb_valid = 1'b0;
    look();
    chk("t3_wake_issue", 128'(iss_valid), 128'(1));
    chk("t3_no_credit", 128'(dsp_ready), 128'(0));
    cyc();
    look();
    chk("t3_ready_after", 128'(dsp_ready), 128'(1));
    chk("t3_occ_after", 128'(occupancy), 128'(3));
    repeat (3) cyc();
    look();
    chk("t3_drained", 128'(occupancy), 128'(0));

    // Same-cycle CDB match at dispatch, both sources, CDB data wins over stale dsp data.
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h1234;
    disp(BGEZ, 64'hD0, 1'b0, 6'd7, 32'hDEAD, 1'b0, 6'd7, 32'hBEEF, 32'h1234, 32'h1234);
    cdb_valid = 1'b0;
    look();
    chk("t4_bypass_issue", 128'(iss_valid), 128'(1));
    cyc();

    flush_test(1'b0);
    flush_test(1'b1);

    // Back-to-back dispatch across pointer wrap.
    issues0 = issues;
    for (int i = 0; i < 10; i++)
      disp(bru_op_t'(12'h001 << (i % 12)), ST_W'(64'hE0 + i), 1'b1, 6'(i), 32'(i * 3),
           1'b1, 6'(i + 1), 32'(i * 5 + 1), 32'(i * 3), 32'(i * 5 + 1));
    repeat (2) cyc();
    look();
    chk("t6_issue_count", 128'(issues - issues0), 128'(10));
    chk("t6_occ", 128'(occupancy), 128'(0));
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
